udp_rx_audio_unpack: RTL

- Receive-direction counterpart of the audio-to-UDP packer in net_top.
- Takes the UDP receive byte stream from eth_udp_test (udp_rec_data_valid / udp_rec_rdata / udp_rec_data_length) and reassembles 16-bit big-endian PCM samples.
- Buffers samples in a sync FIFO and releases one sample per playback strobe (wav_rd_en, one pulse per audio sample period).
- Provides prefill, underrun and overflow handling, plus sticky error flags.

---
 rtl/net_audio_pkg.sv | 19 +
 rtl/audio_sample_fifo.sv | 51 +++++
 rtl/udp_rx_audio_unpack.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/net_audio_pkg.sv
// Shared types and constants for the audio-over-UDP packer/unpacker pair.
package net_audio_pkg;

  localparam int SAMPLE_W          = 16;
  localparam int BYTES_PER_SAMPLE  = 2;
  localparam int PKT_PAYLOAD_BYTES = 960;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_HI,
    RX_LO
  } rx_state_t;

  typedef enum logic {
    FILL,
    PLAY
  } play_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with registered read data; a pop on an empty FIFO is ignored,
// and a push on a full FIFO succeeds only when a pop frees a slot in the same cycle.
module audio_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk_in1,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic              do_push;
  logic              do_pop;

  assign level   = wr_cnt - rd_cnt;
  assign full    = (level == DEPTH[ADDR_W:0]);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_in1) begin
    if (do_push) mem[wr_cnt[ADDR_W-1:0]] <= push_data;
  end

  // rd_data is reset so a hold-last-sample consumer sees 0 before the first pop
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + 1'b1;
      if (do_pop) begin
        rd_cnt  <= rd_cnt + 1'b1;
        rd_data <= mem[rd_cnt[ADDR_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/udp_rx_audio_unpack.sv
// UDP payload bytes -> big-endian 16-bit PCM samples -> FIFO -> one sample per wav_rd_en.
// UDP_RX_UNDERRUN_HOLD_EN: FILL/underrun outputs repeat the last played sample instead of 0.
module udp_rx_audio_unpack #(
  parameter int SAMPLE_W   = net_audio_pkg::SAMPLE_W,
  parameter int FIFO_DEPTH = 1024,
  parameter int PREFILL    = net_audio_pkg::PKT_PAYLOAD_BYTES / net_audio_pkg::BYTES_PER_SAMPLE
) (
  input  logic                          clk_in1,
  input  logic                          rst_n,
  input  logic                          udp_rec_data_valid,
  input  logic [7:0]                    udp_rec_rdata,
  input  logic [15:0]                   udp_rec_data_length,
  input  logic                          wav_rd_en,
  output logic [SAMPLE_W-1:0]           wav_out_data,
  output logic                          wav_out_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          playing,
  output logic                          ovf_err,
  output logic                          udf_err,
  output logic                          len_err,
  input  logic                          err_clr
);

  import net_audio_pkg::*;

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] PREFILL_LVL = PREFILL[ADDR_W:0];

  rx_state_t         rx_state, rx_next;
  play_state_t       play_state, play_next;
  logic [7:0]        hi_byte;
  logic [15:0]       byte_cnt;
  logic [15:0]       len_q;
  logic              push, pop, len_set, udf_set, ovf_set;
  logic              fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_rd_data;

  // RX byte assembly: state register plus per-packet bookkeeping
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      byte_cnt <= '0;
      len_q    <= '0;
    end else begin
      rx_state <= rx_next;
      if (udp_rec_data_valid) begin
        if (rx_state == RX_IDLE) begin
          len_q    <= udp_rec_data_length;
          byte_cnt <= 16'd1;
        end else if (byte_cnt != 16'hFFFF) begin
          byte_cnt <= byte_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in1) begin
    if (udp_rec_data_valid && (rx_state != RX_LO)) hi_byte <= udp_rec_rdata;
  end

  always_comb begin
    rx_next = rx_state;
    if (!udp_rec_data_valid) begin
      rx_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: rx_next = RX_LO;
        RX_LO:   rx_next = RX_HI;
        RX_HI:   rx_next = RX_LO;
        default: rx_next = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    push    = udp_rec_data_valid && (rx_state == RX_LO);
    len_set = !udp_rec_data_valid && (rx_state != RX_IDLE) &&
              ((byte_cnt != len_q) || (rx_state == RX_LO));
  end

  audio_sample_fifo #(
    .DATA_W (SAMPLE_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_in1   (clk_in1),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({hi_byte, udp_rec_rdata}),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Playback FSM
  always_ff @(posedge clk_in1) begin
    if (!rst_n) play_state <= FILL;
    else        play_state <= play_next;
  end

  always_comb begin
    play_next = play_state;
    case (play_state)
      FILL:    if (fifo_level >= PREFILL_LVL) play_next = PLAY;
      PLAY:    if (wav_rd_en && fifo_empty)   play_next = FILL;
      default: play_next = FILL;
    endcase
  end

  always_comb begin
    playing = (play_state == PLAY);
    pop     = playing && wav_rd_en && !fifo_empty;
    udf_set = playing && wav_rd_en && fifo_empty;
    ovf_set = push && fifo_full && !pop;
  end

  // Output stage boundary: valid follows wav_rd_en by one cycle
  always_ff @(posedge clk_in1) begin
    if (!rst_n) wav_out_valid <= 1'b0;
    else        wav_out_valid <= wav_rd_en;
  end

`ifdef UDP_RX_UNDERRUN_HOLD_EN
  // fifo rd_data only changes on a pop, so it already holds the last played sample
  assign wav_out_data = fifo_rd_data;
`else
  logic use_fifo_p1;

  always_ff @(posedge clk_in1) begin
    if (!rst_n)         use_fifo_p1 <= 1'b0;
    else if (wav_rd_en) use_fifo_p1 <= pop;
  end

  assign wav_out_data = use_fifo_p1 ? fifo_rd_data : '0;
`endif

  // Sticky flags: a set in the same cycle as err_clr wins
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
      len_err <= 1'b0;
    end else begin
      ovf_err <= ovf_set || (ovf_err && !err_clr);
      udf_err <= udf_set || (udf_err && !err_clr);
      len_err <= len_set || (len_err && !err_clr);
    end
  end

endmodule
